// File: rtl/cpu_bus_watch.sv
// Bus monitor for the 65C02 memory bus: programmable watchpoints, a cycle timeout
// and a first-word-fall-through trace FIFO of qualified bus cycles.
module cpu_bus_watch #(
    parameter int ADDR_W            = 16,
    parameter int DATA_W            = 8,
    parameter int NUM_WATCH         = 2,
    parameter int TIMEOUT_W         = 24,
    parameter int TRACE_DEPTH       = 16,
    parameter int TRACE_WRITES_ONLY = 0
) (
    input  logic                                              clk,
    input  logic                                              reset_n,
    input  logic [ADDR_W-1:0]                                 AB,
    input  logic [DATA_W-1:0]                                 DO,
    input  logic [DATA_W-1:0]                                 DI,
    input  logic                                              WE,
    input  logic                                              RDY,
    input  logic [NUM_WATCH*ADDR_W-1:0]                       watch_addr,
    input  logic [NUM_WATCH*DATA_W-1:0]                       watch_data,
    input  logic [2*NUM_WATCH-1:0]                            watch_mode,
    input  logic [NUM_WATCH-1:0]                              watch_en,
    input  logic [TIMEOUT_W-1:0]                              timeout_limit,
    input  logic                                              clear,
    output logic                                              halt,
    output logic [1:0]                                        halt_cause,
    output logic [((NUM_WATCH > 1) ? $clog2(NUM_WATCH) : 1)-1:0] halt_index,
    output logic [ADDR_W-1:0]                                 halt_addr,
    output logic [TIMEOUT_W-1:0]                              cycle_count,
    output logic                                              trace_valid,
    input  logic                                              trace_ready,
    output logic [ADDR_W+DATA_W:0]                            trace_data,
    output logic                                              trace_overflow
);

    localparam int IDX_W = (NUM_WATCH > 1) ? $clog2(NUM_WATCH) : 1;
    localparam int TW    = ADDR_W + DATA_W + 1;
    localparam int PTR_W = $clog2(TRACE_DEPTH);

    typedef enum logic {RUN, HALTED} state_t;

    state_t             state, state_next;
    logic [NUM_WATCH-1:0] match;
    logic [1:0]         mode_sel;
    logic               mode_ok;
    logic               watch_hit;
    logic [IDX_W-1:0]   hit_index;
    logic               timeout_hit;
    logic               halt_event;

    logic [PTR_W:0]     wr_ptr, rd_ptr;
    logic [TW-1:0]      mem [TRACE_DEPTH];
    logic               fifo_empty, fifo_full;
    logic               push_req, push, pop;
    logic [TW-1:0]      entry;

    always_comb begin
        match    = '0;
        mode_sel = '0;
        mode_ok  = 1'b0;
        for (int i = 0; i < NUM_WATCH; i++) begin
            mode_sel = watch_mode[2*i +: 2];
            case (mode_sel)
                2'b00:   mode_ok = 1'b1;
                2'b01:   mode_ok = !WE;
                2'b10:   mode_ok = WE;
                default: mode_ok = WE && (DO == watch_data[i*DATA_W +: DATA_W]);
            endcase
            match[i] = RDY && watch_en[i] && (AB == watch_addr[i*ADDR_W +: ADDR_W]) && mode_ok;
        end
    end

    // Scan from the top so the lowest matching index is the one that sticks.
    always_comb begin
        watch_hit = 1'b0;
        hit_index = '0;
        for (int i = NUM_WATCH - 1; i >= 0; i--) begin
            if (match[i]) begin
                watch_hit = 1'b1;
                hit_index = IDX_W'(i);
            end
        end
    end

    assign timeout_hit = (timeout_limit != '0) && (cycle_count == timeout_limit - TIMEOUT_W'(1));
    assign halt_event  = (state == RUN) && (watch_hit || timeout_hit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= RUN;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (clear) state_next = RUN; else if (halt_event) state_next = HALTED;
            HALTED:  if (clear) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    assign halt = (state == HALTED);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_count <= '0;
            halt_cause  <= 2'b00;
            halt_index  <= '0;
            halt_addr   <= '0;
        end else if (clear) begin
            cycle_count <= '0;
            halt_cause  <= 2'b00;
            halt_index  <= '0;
            halt_addr   <= '0;
        end else if (state == RUN) begin
            if (cycle_count != '1) cycle_count <= cycle_count + TIMEOUT_W'(1);
            if (halt_event) begin
                halt_cause <= watch_hit ? 2'b01 : 2'b10;
                halt_index <= watch_hit ? hit_index : '0;
                halt_addr  <= AB;
            end
        end
    end

    // A full FIFO still accepts a push when the head is leaving in the same clock.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign push_req   = (state == RUN) && RDY && ((TRACE_WRITES_ONLY == 0) || WE);
    assign pop        = !fifo_empty && trace_ready;
    assign push       = push_req && (!fifo_full || pop);
    assign entry      = {WE, AB, (WE ? DO : DI)};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            trace_overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            trace_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            if (push_req && fifo_full && !pop) trace_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr[PTR_W-1:0]] <= entry;
    end

    assign trace_valid = !fifo_empty;
    assign trace_data  = fifo_empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: tb/tb_cpu_bus_watch.sv
// Self-checking bench for cpu_bus_watch: a queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_cpu_bus_watch;

    localparam int ADDR_W            = 16;
    localparam int DATA_W            = 8;
    localparam int NUM_WATCH         = 2;
    localparam int TIMEOUT_W         = 24;
    localparam int TRACE_DEPTH       = 4;
    localparam int TRACE_WRITES_ONLY = 0;
    localparam int MAX_COUNT         = (1 << TIMEOUT_W) - 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] AB;
    logic [7:0]  DO, DI;
    logic        WE, RDY;
    logic [31:0] watch_addr;
    logic [15:0] watch_data;
    logic [3:0]  watch_mode;
    logic [1:0]  watch_en;
    logic [23:0] timeout_limit;
    logic        clear;
    logic        trace_ready;
    logic        halt;
    logic [1:0]  halt_cause;
    logic [0:0]  halt_index;
    logic [15:0] halt_addr;
    logic [23:0] cycle_count;
    logic        trace_valid;
    logic [24:0] trace_data;
    logic        trace_overflow;

    int checks_total  = 0;
    int checks_passed = 0;

    cpu_bus_watch #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_WATCH(NUM_WATCH), .TIMEOUT_W(TIMEOUT_W),
        .TRACE_DEPTH(TRACE_DEPTH), .TRACE_WRITES_ONLY(TRACE_WRITES_ONLY)
    ) dut (
        .clk(clk), .reset_n(reset_n), .AB(AB), .DO(DO), .DI(DI), .WE(WE), .RDY(RDY),
        .watch_addr(watch_addr), .watch_data(watch_data), .watch_mode(watch_mode),
        .watch_en(watch_en), .timeout_limit(timeout_limit), .clear(clear),
        .halt(halt), .halt_cause(halt_cause), .halt_index(halt_index), .halt_addr(halt_addr),
        .cycle_count(cycle_count), .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_data(trace_data), .trace_overflow(trace_overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    endtask

    // Reference model: halted flag, integer counter and a queue standing in for the FIFO.
    logic        m_halted;
    logic [1:0]  m_cause;
    int          m_index;
    logic [15:0] m_addr;
    int          m_count;
    logic [24:0] m_q[$];
    logic        m_ovf;

    task automatic model_reset();
        m_halted = 1'b0;
        m_cause  = 2'b00;
        m_index  = 0;
        m_addr   = '0;
        m_count  = 0;
        m_q.delete();
        m_ovf    = 1'b0;
    endtask

    task automatic model_step();
        bit pop_ok, hit, tmo, cond;
        int idx;
        if (clear) begin
            model_reset();
            return;
        end
        pop_ok = (m_q.size() > 0) && trace_ready;
        hit = 1'b0;
        idx = 0;
        for (int i = 0; i < NUM_WATCH; i++) begin
            case (watch_mode[2*i +: 2])
                2'b00:   cond = 1'b1;
                2'b01:   cond = !WE;
                2'b10:   cond = WE;
                default: cond = WE && (DO == watch_data[8*i +: 8]);
            endcase
            if (!hit && RDY && watch_en[i] && AB == watch_addr[16*i +: 16] && cond) begin
                hit = 1'b1;
                idx = i;
            end
        end
        tmo = (timeout_limit != 0) && (m_count == int'(timeout_limit) - 1);
        if (pop_ok) void'(m_q.pop_front());
        if (!m_halted) begin
            if (RDY && (TRACE_WRITES_ONLY == 0 || WE)) begin
                if (m_q.size() < TRACE_DEPTH) m_q.push_back({WE, AB, (WE ? DO : DI)});
                else m_ovf = 1'b1;
            end
            if (hit || tmo) begin
                m_halted = 1'b1;
                m_cause  = hit ? 2'b01 : 2'b10;
                m_index  = hit ? idx : 0;
                m_addr   = AB;
            end
            if (m_count < MAX_COUNT) m_count++;
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step();
    end

    always @(negedge clk) begin
        checkOutput("cmp_halt", halt, m_halted);
        checkOutput("cmp_cause", halt_cause, m_cause);
        checkOutput("cmp_index", halt_index, m_index);
        checkOutput("cmp_addr", halt_addr, m_addr);
        checkOutput("cmp_count", cycle_count, m_count);
        checkOutput("cmp_valid", trace_valid, m_q.size() != 0);
        checkOutput("cmp_data", trace_data, (m_q.size() != 0) ? m_q[0] : 25'h0);
        checkOutput("cmp_overflow", trace_overflow, m_ovf);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] ab, input logic [7:0] dout,
                                 input logic [7:0] din, input logic we, input logic rdy);
        AB  = ab;
        DO  = dout;
        DI  = din;
        WE  = we;
        RDY = rdy;
        tick();
    endtask

    task automatic idle();
        applyStimulus(16'h0000, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic doClear();
        clear = 1'b1;
        idle();
        clear = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        AB = '0; DO = '0; DI = '0; WE = 1'b0; RDY = 1'b0;
        watch_addr = '0; watch_data = '0; watch_mode = '0; watch_en = '0;
        timeout_limit = '0; clear = 1'b0; trace_ready = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) tick();
        checkOutput("rst_halt", halt, 1'b0);
        checkOutput("rst_count", cycle_count, 0);
        checkOutput("rst_valid", trace_valid, 1'b0);
        checkOutput("rst_data", trace_data, 0);
        checkOutput("rst_overflow", trace_overflow, 1'b0);

        // Single watchpoint, mode any, hit on the fifth clock after release
        watch_addr[15:0] = 16'hBEEF;
        watch_mode[1:0]  = 2'b00;
        watch_en         = 2'b01;
        reset_n = 1'b1;
        repeat (4) idle();
        applyStimulus(16'hBEEF, 8'h00, 8'h12, 1'b0, 1'b1);
        checkOutput("beef_halt", halt, 1'b1);
        checkOutput("beef_cause", halt_cause, 2'b01);
        checkOutput("beef_index", halt_index, 0);
        checkOutput("beef_addr", halt_addr, 16'hBEEF);
        checkOutput("beef_count", cycle_count, 5);
        checkOutput("beef_trace", trace_data, 25'h0BEEF12);
        applyStimulus(16'hBEEF, 8'h34, 8'h00, 1'b1, 1'b1);
        checkOutput("halted_count_frozen", cycle_count, 5);
        checkOutput("halted_no_push", trace_valid, 1'b0);
        doClear();
        checkOutput("clear_halt", halt, 1'b0);
        checkOutput("clear_count", cycle_count, 0);
        checkOutput("clear_addr", halt_addr, 0);

        // Data-match mode, then RDY gating, then read-only mode
        watch_addr[15:0] = 16'h0200;
        watch_data[7:0]  = 8'h55;
        watch_mode[1:0]  = 2'b11;
        applyStimulus(16'h0200, 8'hAA, 8'h00, 1'b1, 1'b1);
        checkOutput("m11_wrong_data", halt, 1'b0);
        applyStimulus(16'h0200, 8'h55, 8'h00, 1'b1, 1'b1);
        checkOutput("m11_hit", halt, 1'b1);
        checkOutput("m11_addr", halt_addr, 16'h0200);
        doClear();
        applyStimulus(16'h0200, 8'h55, 8'h00, 1'b1, 1'b0);
        checkOutput("m11_rdy_low", halt, 1'b0);
        applyStimulus(16'h0200, 8'h00, 8'h55, 1'b0, 1'b1);
        checkOutput("m11_read", halt, 1'b0);
        watch_mode[1:0] = 2'b01;
        applyStimulus(16'h0200, 8'h55, 8'h00, 1'b1, 1'b1);
        checkOutput("m01_write", halt, 1'b0);
        applyStimulus(16'h0200, 8'h00, 8'h77, 1'b0, 1'b1);
        checkOutput("m01_read", halt, 1'b1);
        doClear();

        // Timeout of 100 clocks after clear, alone and coinciding with a watch hit
        watch_en = 2'b00;
        timeout_limit = 24'd100;
        doClear();
        repeat (99) idle();
        checkOutput("tmo_before", halt, 1'b0);
        checkOutput("tmo_count99", cycle_count, 99);
        idle();
        checkOutput("tmo_halt", halt, 1'b1);
        checkOutput("tmo_cause", halt_cause, 2'b10);
        checkOutput("tmo_count100", cycle_count, 100);
        watch_addr[15:0] = 16'h4000;
        watch_mode[1:0]  = 2'b00;
        watch_en         = 2'b01;
        doClear();
        repeat (99) idle();
        checkOutput("tie_before", halt, 1'b0);
        applyStimulus(16'h4000, 8'h00, 8'h00, 1'b0, 1'b1);
        checkOutput("tie_halt", halt, 1'b1);
        checkOutput("tie_cause", halt_cause, 2'b01);
        timeout_limit = '0;
        doClear();

        // Priority between identical watchpoints
        watch_addr = {16'h3000, 16'h3000};
        watch_mode = 4'b0000;
        watch_en   = 2'b11;
        applyStimulus(16'h3000, 8'h00, 8'h00, 1'b0, 1'b1);
        checkOutput("prio_halt", halt, 1'b1);
        checkOutput("prio_index0", halt_index, 0);
        doClear();
        watch_en = 2'b10;
        applyStimulus(16'h3000, 8'h00, 8'h00, 1'b0, 1'b1);
        checkOutput("prio_index1", halt_index, 1);
        watch_en = 2'b00;
        doClear();

        // Trace FIFO fill, overflow, push+pop when full, drain, empty push+pop
        trace_ready = 1'b0;
        doClear();
        applyStimulus(16'h1000, 8'h11, 8'hDD, 1'b1, 1'b1);
        applyStimulus(16'h1001, 8'hEE, 8'h22, 1'b0, 1'b1);
        applyStimulus(16'h1002, 8'h33, 8'hDD, 1'b1, 1'b1);
        applyStimulus(16'h1003, 8'hEE, 8'h44, 1'b0, 1'b1);
        applyStimulus(16'h1004, 8'h55, 8'hDD, 1'b1, 1'b1);
        applyStimulus(16'h1005, 8'hEE, 8'h66, 1'b0, 1'b1);
        checkOutput("fifo_overflow", trace_overflow, 1'b1);
        checkOutput("fifo_head0", trace_data, 25'h1100011);
        trace_ready = 1'b1;
        applyStimulus(16'h1006, 8'h77, 8'hDD, 1'b1, 1'b1);
        checkOutput("fifo_head1", trace_data, 25'h0100122);
        idle();
        checkOutput("fifo_head2", trace_data, 25'h1100233);
        idle();
        checkOutput("fifo_head3", trace_data, 25'h0100344);
        idle();
        checkOutput("fifo_head_pushpop", trace_data, 25'h1100677);
        idle();
        checkOutput("fifo_drained", trace_valid, 1'b0);
        checkOutput("fifo_overflow_sticky", trace_overflow, 1'b1);
        applyStimulus(16'h1007, 8'h88, 8'hDD, 1'b1, 1'b1);
        checkOutput("fifo_empty_pushpop", trace_data, 25'h1100788);
        trace_ready = 1'b0;
        clear = 1'b1;
        applyStimulus(16'h1008, 8'h99, 8'h00, 1'b1, 1'b1);
        clear = 1'b0;
        checkOutput("clear_push_valid", trace_valid, 1'b0);
        checkOutput("clear_push_overflow", trace_overflow, 1'b0);
        idle();

        // Asynchronous reset mid-run while halted with a full, overflowed FIFO
        watch_addr[15:0] = 16'h2004;
        watch_mode[1:0]  = 2'b00;
        watch_en         = 2'b01;
        for (int i = 0; i < 5; i++) applyStimulus(16'h2000 + 16'(i), 8'(i), 8'h00, 1'b1, 1'b1);
        checkOutput("pre_rst_halt", halt, 1'b1);
        checkOutput("pre_rst_overflow", trace_overflow, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_halt", halt, 1'b0);
        checkOutput("async_cause", halt_cause, 2'b00);
        checkOutput("async_addr", halt_addr, 0);
        checkOutput("async_count", cycle_count, 0);
        checkOutput("async_valid", trace_valid, 1'b0);
        checkOutput("async_data", trace_data, 0);
        checkOutput("async_overflow", trace_overflow, 1'b0);
        idle();
        reset_n = 1'b1;
        repeat (3) idle();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
